pipe_track: RTL and testbench

Pipeline bookkeeping block for the four-register pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries per-instruction control metadata through the latch chain and applies the hazard unit's `stall_*` and `flush_*` commands to that chain. From the tracked state it produces the hazard unit's inputs: `mwb_rd`, `idex_rs`, `load`, `dmemREN`, `dmemWEN` and `halt`. It also counts retired instructions.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/hazard_unit_if.sv | 32 +++
 rtl/pipe_stage_reg.sv | 30 +++
 rtl/pipe_track.sv | 131 +++++++++++++
 tb/tb_pipe_track.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register field type and the per-stage control bundle
// carried through the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef struct packed {
        logic     valid;
        regbits_t rs;
        regbits_t rt;
        regbits_t rd;
        logic     regWEN;
        logic     dmemREN;
        logic     dmemWEN;
        logic     halt;
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_BUBBLE = '0;

    // True when older stage p writes a nonzero register that younger stage c reads.
    function automatic logic writes_src(input stage_ctrl_t p, input stage_ctrl_t c);
        return p.valid & c.valid & p.regWEN & (p.rd != '0) &
               ((p.rd == c.rs) | (p.rd == c.rt));
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Handshake bundle between the hazard unit (hzu) and pipe_track (trk).
// Ports: stall_*/flush_* from hzu to trk; hazard flags and halt from trk to hzu.
interface hazard_unit_if;

    logic stall_ifid;
    logic stall_idex;
    logic stall_xmem;
    logic stall_wb;
    logic flush_ifid;
    logic flush_idex;
    logic flush_xmem;
    logic flush_wb;
    logic mwb_rd;
    logic idex_rs;
    logic load;
    logic dmemREN;
    logic dmemWEN;
    logic halt;

    modport hzu (
        input  mwb_rd, idex_rs, load, dmemREN, dmemWEN, halt,
        output stall_ifid, stall_idex, stall_xmem, stall_wb,
        output flush_ifid, flush_idex, flush_xmem, flush_wb
    );

    modport trk (
        output mwb_rd, idex_rs, load, dmemREN, dmemWEN, halt,
        input  stall_ifid, stall_idex, stall_xmem, stall_wb,
        input  flush_ifid, flush_idex, flush_xmem, flush_wb
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register holding a stage_ctrl_t.
// Ports: CLK, RST (sync, active-high), stall/flush/bubble controls, d in, q out.
module pipe_stage_reg
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall,
    input  logic        flush,
    input  logic        bubble,
    input  stage_ctrl_t d,
    output stage_ctrl_t q
);

    // Flush outranks stall; bubble is inserted when the upstream stage holds.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q <= STAGE_BUBBLE;
        end else if (flush) begin
            q <= STAGE_BUBBLE;
        end else if (stall) begin
            q <= q;
        end else if (bubble) begin
            q <= STAGE_BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_track.sv
// Pipeline bookkeeping: tracks control metadata through the four stage
// registers, derives hazard flags, latches halt and counts retirements.
// Ports: CLK, RST (sync, active-high); if_* decoded bundle in;
// stall_*/flush_* per stage in; mwb_rd, idex_rs, load, dmemREN, dmemWEN,
// halt, retired out.
module pipe_track
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             if_valid,
    input  regbits_t         if_rs,
    input  regbits_t         if_rt,
    input  regbits_t         if_rd,
    input  logic             if_regWEN,
    input  logic             if_dmemREN,
    input  logic             if_dmemWEN,
    input  logic             if_halt,
    input  logic             stall_ifid,
    input  logic             stall_idex,
    input  logic             stall_xmem,
    input  logic             stall_wb,
    input  logic             flush_ifid,
    input  logic             flush_idex,
    input  logic             flush_xmem,
    input  logic             flush_wb,
    output logic             mwb_rd,
    output logic             idex_rs,
    output logic             load,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             halt,
    output logic [CNT_W-1:0] retired
);

    stage_ctrl_t if_d;
    stage_ctrl_t ifid_q;
    stage_ctrl_t idex_q;
    stage_ctrl_t xmem_q;
    stage_ctrl_t wb_q;
    logic        retire_go;
    logic        unused_wb;

    // Once halted, fetch is starved by presenting an invalid instruction.
    always_comb begin
        if_d         = STAGE_BUBBLE;
        if_d.valid   = if_valid & ~halt;
        if_d.rs      = if_rs;
        if_d.rt      = if_rt;
        if_d.rd      = if_rd;
        if_d.regWEN  = if_regWEN;
        if_d.dmemREN = if_dmemREN;
        if_d.dmemWEN = if_dmemWEN;
        if_d.halt    = if_halt;
    end

    pipe_stage_reg u_ifid (
        .CLK    (CLK),
        .RST    (RST),
        .stall  (stall_ifid),
        .flush  (flush_ifid),
        .bubble (1'b0),
        .d      (if_d),
        .q      (ifid_q)
    );

    pipe_stage_reg u_idex (
        .CLK    (CLK),
        .RST    (RST),
        .stall  (stall_idex),
        .flush  (flush_idex),
        .bubble (stall_ifid),
        .d      (ifid_q),
        .q      (idex_q)
    );

    pipe_stage_reg u_xmem (
        .CLK    (CLK),
        .RST    (RST),
        .stall  (stall_xmem),
        .flush  (flush_xmem),
        .bubble (stall_idex),
        .d      (idex_q),
        .q      (xmem_q)
    );

    pipe_stage_reg u_wb (
        .CLK    (CLK),
        .RST    (RST),
        .stall  (stall_wb),
        .flush  (flush_wb),
        .bubble (stall_xmem),
        .d      (xmem_q),
        .q      (wb_q)
    );

    // Hazard flags come only from registered state.
    always_comb begin
        idex_rs = writes_src(xmem_q, idex_q);
        mwb_rd  = writes_src(wb_q, idex_q);
        load    = idex_rs & xmem_q.dmemREN;
        dmemREN = xmem_q.valid & xmem_q.dmemREN;
        dmemWEN = xmem_q.valid & xmem_q.dmemWEN;
    end

    assign unused_wb = ^{wb_q.rs, wb_q.rt, wb_q.dmemREN, wb_q.dmemWEN};

    // An instruction retires when it leaves MEM/WB undisturbed.
    assign retire_go = wb_q.valid & ~stall_wb & ~flush_wb;

    always_ff @(posedge CLK) begin
        if (RST) begin
            halt <= 1'b0;
        end else if (retire_go & wb_q.halt) begin
            halt <= 1'b1;
        end
    end

    // The halt itself is counted: halt is still 0 on its retiring edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            retired <= '0;
        end else if (retire_go & ~halt) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_track.sv
// Directed scoreboard bench for pipe_track.
// Expectations are queued with stimulus and checked when the DUT responds.
module tb_pipe_track;

    logic        CLK;
    logic        RST;
    logic        if_valid;
    logic [4:0]  if_rs;
    logic [4:0]  if_rt;
    logic [4:0]  if_rd;
    logic        if_regWEN;
    logic        if_dmemREN;
    logic        if_dmemWEN;
    logic        if_halt;
    logic        stall_ifid;
    logic        stall_idex;
    logic        stall_xmem;
    logic        stall_wb;
    logic        flush_ifid;
    logic        flush_idex;
    logic        flush_xmem;
    logic        flush_wb;
    logic        mwb_rd;
    logic        idex_rs;
    logic        load;
    logic        dmemREN;
    logic        dmemWEN;
    logic        halt;
    logic [31:0] retired;
    logic        mwb_rd4;
    logic        idex_rs4;
    logic        load4;
    logic        dmemREN4;
    logic        dmemWEN4;
    logic        halt4;
    logic [3:0]  retired4;

    int total;
    int bad;

    string       tag_q[$];
    logic [47:0] exp_q[$];

    pipe_track dut (
        .CLK(CLK), .RST(RST),
        .if_valid(if_valid), .if_rs(if_rs), .if_rt(if_rt), .if_rd(if_rd),
        .if_regWEN(if_regWEN), .if_dmemREN(if_dmemREN),
        .if_dmemWEN(if_dmemWEN), .if_halt(if_halt),
        .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_xmem(stall_xmem), .stall_wb(stall_wb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_xmem(flush_xmem), .flush_wb(flush_wb),
        .mwb_rd(mwb_rd), .idex_rs(idex_rs), .load(load),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .halt(halt),
        .retired(retired)
    );

    pipe_track #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST),
        .if_valid(if_valid), .if_rs(if_rs), .if_rt(if_rt), .if_rd(if_rd),
        .if_regWEN(if_regWEN), .if_dmemREN(if_dmemREN),
        .if_dmemWEN(if_dmemWEN), .if_halt(if_halt),
        .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_xmem(stall_xmem), .stall_wb(stall_wb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_xmem(flush_xmem), .flush_wb(flush_wb),
        .mwb_rd(mwb_rd4), .idex_rs(idex_rs4), .load(load4),
        .dmemREN(dmemREN4), .dmemWEN(dmemWEN4), .halt(halt4),
        .retired(retired4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic wen, input logic ren,
                         input logic mwen, input logic hlt);
        if_valid   = v;
        if_rs      = rs;
        if_rt      = rt;
        if_rd      = rd;
        if_regWEN  = wen;
        if_dmemREN = ren;
        if_dmemWEN = mwen;
        if_halt    = hlt;
    endtask

    task automatic idle();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic no_ctl();
        stall_ifid = 1'b0;
        stall_idex = 1'b0;
        stall_xmem = 1'b0;
        stall_wb   = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        flush_xmem = 1'b0;
        flush_wb   = 1'b0;
    endtask

    // h = {mwb_rd, idex_rs, load, dmemREN, dmemWEN, halt}; r = retire count.
    // The 4-bit instance sees the same hazards and the count modulo 16.
    task automatic expect_out(input string tag, input logic [5:0] h, input logic [31:0] r);
        tag_q.push_back(tag);
        exp_q.push_back({h, r, h, r[3:0]});
    endtask

    task automatic check_out();
        string       t;
        logic [47:0] e;
        logic [47:0] o;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        o = {mwb_rd, idex_rs, load, dmemREN, dmemWEN, halt, retired,
             mwb_rd4, idex_rs4, load4, dmemREN4, dmemWEN4, halt4, retired4};
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        no_ctl();

        // reset with a valid instruction on the inputs
        RST = 1'b1;
        issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        RST = 1'b0;
        idle();
        expect_out("reset", 6'b000000, 0);
        check_out();
        expect_out("post_reset", 6'b000000, 0);
        tick();
        check_out();

        // forwarding: rd=5 producer, rs=5 consumer, rt=5 consumer
        issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("fwd_exmem", 6'b010000, 0);
        tick();
        check_out();
        idle();
        expect_out("fwd_memwb", 6'b100000, 0);
        tick();
        check_out();
        repeat (4) tick();
        expect_out("fwd_drain", 6'b000000, 3);
        check_out();

        // same pattern through register 0
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("rd0_exmem", 6'b000000, 3);
        tick();
        check_out();
        idle();
        expect_out("rd0_memwb", 6'b000000, 3);
        tick();
        check_out();
        repeat (4) tick();
        expect_out("rd0_drain", 6'b000000, 6);
        check_out();

        // load-use, then stall front + flush EX/MEM
        issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd2, 5'd7, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("loaduse", 6'b011100, 6);
        tick();
        check_out();
        stall_ifid = 1'b1;
        stall_idex = 1'b1;
        flush_xmem = 1'b1;
        issue(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1);
        expect_out("loaduse_bubble", 6'b100000, 6);
        tick();
        check_out();
        no_ctl();
        idle();
        expect_out("loaduse_resume", 6'b000000, 7);
        tick();
        check_out();
        expect_out("store", 6'b000010, 7);
        tick();
        check_out();
        tick();
        tick();
        expect_out("store_drain", 6'b000000, 9);
        check_out();

        // flush and stall on ID/EX together
        issue(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        stall_ifid = 1'b1;
        stall_idex = 1'b1;
        flush_idex = 1'b1;
        idle();
        expect_out("flush_over_stall", 6'b000000, 9);
        tick();
        check_out();
        no_ctl();
        expect_out("flush_no_fwd", 6'b000000, 9);
        tick();
        check_out();
        repeat (3) tick();
        expect_out("flush_drain", 6'b000000, 10);
        check_out();

        // hold IF/ID and ID/EX for three cycles against changing inputs
        issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        stall_ifid = 1'b1;
        stall_idex = 1'b1;
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_out("stall_hold", 6'b000000, 10);
            tick();
            check_out();
        end
        no_ctl();
        idle();
        expect_out("stall_release_fwd", 6'b010000, 10);
        tick();
        check_out();
        repeat (3) tick();
        expect_out("stall_drain", 6'b000000, 12);
        check_out();

        // halt drain from a fresh reset
        RST = 1'b1;
        idle();
        tick();
        RST = 1'b0;
        expect_out("halt_reset", 6'b000000, 0);
        check_out();
        repeat (3) begin
            issue(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        issue(1'b1, 5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        expect_out("halt_pre", 6'b010000, 3);
        check_out();
        expect_out("halt_set", 6'b110001, 4);
        tick();
        check_out();
        expect_out("halt_inflight", 6'b110001, 4);
        tick();
        check_out();
        for (int i = 0; i < 9; i++) begin
            expect_out("halt_frozen", 6'b000001, 4);
            tick();
            check_out();
        end

        // reset clears a latched halt
        RST = 1'b1;
        idle();
        tick();
        RST = 1'b0;
        expect_out("halt_cleared", 6'b000000, 0);
        check_out();

        // retire 17: 4-bit counter wraps to 1
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (17) tick();
        idle();
        repeat (3) tick();
        expect_out("wrap_16", 6'b000000, 16);
        check_out();
        expect_out("wrap_17", 6'b000000, 17);
        tick();
        check_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
